// File: rtl/itrx_aib_phy_tx_ddr_ser_pkg.sv
// Shared types and pattern constants for the AIB PHY transmit DDR launch path.
// The state encoding is fixed so that the RX side and debug tooling decode it identically.
package itrx_aib_phy_tx_ddr_ser_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } tx_state_e;

  // Per-pin training levels: even half high, odd half low, so every pin toggles each half-cycle.
  localparam logic TRAIN_EVEN_BIT = 1'b1;
  localparam logic TRAIN_ODD_BIT  = 1'b0;
  localparam logic IDLE_BIT       = 1'b0;

endpackage

// File: rtl/itrx_aib_phy_tx_ddr_ser_fifo.sv
// Small synchronous FIFO with flush, occupancy count and registered full/empty.
// There is no bypass path; also used by the RX deskew path.
module itrx_aib_phy_sync_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             doPush, doPop;

  assign doPush = push_i && !full_q && !flush_i;
  assign doPop  = pop_i && !empty_q && !flush_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (doPush) wptr_d = wptr_q + AW'(1);
      if (doPop)  rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(doPush) - CW'(doPop);
    end
    full_d  = (count_d == FULL_COUNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/itrx_aib_phy_tx_ddr_ser.sv
// AIB PHY transmit DDR launch: buffers full-rate words, sends a training pattern after
// enable, then presents each word as registered even/odd halves to the downstream DDR mux.
module itrx_aib_phy_tx_ddr_ser
  import itrx_aib_phy_tx_ddr_ser_pkg::*;
#(
  parameter int DWIDTH    = 20,
  parameter int DEPTH     = 4,
  parameter int TRAIN_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic [2*DWIDTH-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DWIDTH-1:0]     dout_even,
  output logic [DWIDTH-1:0]     dout_odd,
  output logic                  tx_active,
  output logic                  underflow
);

  localparam int TCW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
  localparam logic [TCW-1:0] TRAIN_LAST = TCW'(TRAIN_LEN - 1);
  localparam int FCW = $clog2(DEPTH) + 1;

  tx_state_e           state_q, state_d;
  logic [TCW-1:0]      tcnt_q, tcnt_d;
  logic [DWIDTH-1:0]   even_q, even_d, odd_q, odd_d;
  logic                sent_q, sent_d, uf_q, uf_d;
  logic                loadRun, popReq, fifoFull, fifoEmpty;
  logic [2*DWIDTH-1:0] fifoHead;
  logic [FCW-1:0]      fifoCount;

  assign in_ready = (state_q != ST_OFF) && !fifoFull;

  itrx_aib_phy_sync_fifo #(
    .WIDTH (2*DWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (!tx_en),
    .push_i  (in_valid && in_ready),
    .pop_i   (popReq),
    .wdata_i (in_data),
    .rdata_o (fifoHead),
    .count_o (fifoCount),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    even_d  = even_q;
    odd_d   = odd_q;
    sent_d  = sent_q;
    uf_d    = uf_q;
    loadRun = 1'b0;
    popReq  = 1'b0;
    if (!tx_en) begin
      state_d = ST_OFF;
      tcnt_d  = '0;
      even_d  = '0;
      odd_d   = '0;
      sent_d  = 1'b0;
      uf_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          state_d = ST_TRAIN;
          tcnt_d  = '0;
          even_d  = {DWIDTH{TRAIN_EVEN_BIT}};
          odd_d   = {DWIDTH{TRAIN_ODD_BIT}};
        end
        ST_TRAIN: begin
          // The edge that ends training is also the first RUN output load.
          if (tcnt_q == TRAIN_LAST) begin
            state_d = ST_RUN;
            loadRun = 1'b1;
          end else begin
            tcnt_d = tcnt_q + TCW'(1);
          end
        end
        ST_RUN:  loadRun = 1'b1;
        default: state_d = ST_OFF;
      endcase
      if (loadRun) begin
        if (!fifoEmpty) begin
          popReq = 1'b1;
          even_d = fifoHead[DWIDTH-1:0];
          odd_d  = fifoHead[2*DWIDTH-1:DWIDTH];
          sent_d = 1'b1;
        end else if (fifoCount == '0) begin
          even_d = {DWIDTH{IDLE_BIT}};
          odd_d  = {DWIDTH{IDLE_BIT}};
          if (sent_q) uf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      tcnt_q  <= '0;
      even_q  <= '0;
      odd_q   <= '0;
      sent_q  <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      even_q  <= even_d;
      odd_q   <= odd_d;
      sent_q  <= sent_d;
      uf_q    <= uf_d;
    end
  end

  assign dout_even = even_q;
  assign dout_odd  = odd_q;
  assign tx_active = (state_q == ST_RUN);
  assign underflow = uf_q;

endmodule

// File: tb/tb_itrx_aib_phy_tx_ddr_ser.sv
// Scoreboard bench for the AIB transmit DDR launch block: a queue-based reference model
// predicts every post-edge output and a negedge monitor compares the DUT against it.
module tb_itrx_aib_phy_tx_ddr_ser;

  localparam int DW    = 20;
  localparam int DEPTH = 4;
  localparam int TL    = 8;

  logic          clk = 1'b0;
  logic          rst, tx_en, in_valid, in_ready, tx_active, underflow;
  logic [2*DW-1:0] in_data;
  logic [DW-1:0] dout_even, dout_odd;

  always #5 clk = ~clk;

  itrx_aib_phy_tx_ddr_ser #(.DWIDTH(DW), .DEPTH(DEPTH), .TRAIN_LEN(TL)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_en     (tx_en),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dout_even (dout_even),
    .dout_odd  (dout_odd),
    .tx_active (tx_active),
    .underflow (underflow)
  );

  typedef struct {
    logic [DW-1:0] even;
    logic [DW-1:0] odd;
    bit            active;
    bit            uf;
    bit            ready;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: link phase, remaining training cycles, and the buffered words.
  bit              mOn = 0, mRun = 0, mSent = 0, mUf = 0, mAccept = 1;
  int              mTrainLeft = 0;
  logic [2*DW-1:0] mFifo[$];
  logic [DW-1:0]   mE = '0, mO = '0;
  logic [2*DW-1:0] curData = '0;

  task automatic applyStimulus(input bit r, input bit en, input bit v, input logic [2*DW-1:0] d);
    bit ready;
    logic [2*DW-1:0] w;
    rst = r; tx_en = en; in_valid = v; in_data = d;
    ready   = mOn && (mFifo.size() < DEPTH);
    mAccept = v && ready && !r;
    if (r || !en) begin
      mOn = 0; mRun = 0; mSent = 0; mUf = 0; mTrainLeft = 0;
      mFifo.delete(); mE = '0; mO = '0;
      mAccept = 0;
    end else if (!mOn) begin
      mOn = 1; mTrainLeft = TL; mE = '1; mO = '0;
    end else begin
      if (mTrainLeft > 1) begin
        mTrainLeft--; mE = '1; mO = '0;
      end else begin
        mTrainLeft = 0; mRun = 1;
        if (mFifo.size() > 0) begin
          w = mFifo.pop_front();
          mE = w[DW-1:0]; mO = w[2*DW-1:DW]; mSent = 1;
        end else begin
          mE = '0; mO = '0;
          if (mSent) mUf = 1;
        end
      end
      if (mAccept) mFifo.push_back(d);
    end
    expQ.push_back('{even: mE, odd: mO, active: mRun, uf: mUf,
                     ready: mOn && (mFifo.size() < DEPTH)});
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("dout_even", dout_even, e.even);
    cmp("dout_odd",  dout_odd,  e.odd);
    cmp("tx_active", DW'(tx_active), DW'(e.active));
    cmp("underflow", DW'(underflow), DW'(e.uf));
    cmp("in_ready",  DW'(in_ready),  DW'(e.ready));
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) applyStimulus(0, en, 0, curData);
  endtask

  // Offer a word until the model accepts it, bounded so a stuck ready cannot hang the run.
  task automatic sendWord(input logic [2*DW-1:0] w);
    int n = 0;
    do begin
      applyStimulus(0, 1, 1, w);
      n++;
    end while (!mAccept && n < 20);
    checks++;
    if (!mAccept) begin
      failures++;
      $display("[TB] FAIL send_timeout word %h not accepted within %0d cycles", w, n);
    end
  endtask

  task automatic newRandomData();
    logic [63:0] r64;
    r64 = {$urandom(), $urandom()};
    curData = r64[2*DW-1:0];
  endtask

  initial begin
    int pValid;
    bit en, v;
    rst = 1; tx_en = 1; in_valid = 0; in_data = '0;
    #1;
    // Reset held with tx_en high, then training with two buffered words and an idle tail.
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, '0);
    applyStimulus(0, 1, 0, '0);
    applyStimulus(0, 1, 1, 40'hABCDE12345);
    applyStimulus(0, 1, 1, 40'h0000100002);
    idle(10, 1);

    // Training again after a one-cycle disable, offering six words to overfill the FIFO.
    idle(1, 0);
    applyStimulus(0, 1, 0, '0);
    for (int k = 0; k < 6; k++) sendWord(40'h11111_00000 + 40'(k));
    idle(6, 1);

    // Back-to-back incrementing stream in RUN.
    for (int k = 0; k < 100; k++) sendWord({20'(k), 20'(k + 1000)});
    idle(3, 1);

    // Three words queued during training, then a single-cycle disable discards them.
    idle(1, 0);
    applyStimulus(0, 1, 0, '0);
    for (int k = 0; k < 3; k++) sendWord(40'hDEAD0_00000 + 40'(k));
    idle(1, 0);
    idle(TL + 4, 1);

    // Randomized traffic with occasional disables and resets.
    pValid = 50;
    newRandomData();
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) pValid = $urandom_range(100);
      en = ($urandom_range(149) != 0);
      v  = ($urandom_range(99) < pValid);
      if ($urandom_range(499) == 0) applyStimulus(1, en, v, curData);
      else applyStimulus(0, en, v, curData);
      if (mAccept || !v) newRandomData();
    end
    idle(4, 1);

    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
